// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Brief    : MIPS instruction-fetch stage with PC register and IF/ID latch.
//             Optional performance counters enabled by IF_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFstall,
    input  logic        IDstall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc4,
    output logic        IF_ID_valid,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble,
`endif
    output logic        if_state
);

    localparam logic [0:0] c_st_fetch  = 1'b0;
    localparam logic [0:0] c_st_bubble = 1'b1;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [0:0]  r_state;
    logic [31:0] w_pc_plus4;
    logic        w_unused_tgt;

    assign w_pc_plus4   = r_pc + 32'd4;
    // Targets are forced word aligned, so the low bits are dropped.
    assign w_unused_tgt = ^br_target[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= {RESET_PC[31:2], 2'b00};
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            r_state <= c_st_fetch;
        end else if (br_taken) begin
            r_pc    <= {br_target[31:2], 2'b00};
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            r_state <= c_st_fetch;
        end else if (!IDstall) begin
            if (IFstall) begin
                r_instr <= NOP_INSTR;
                r_pc4   <= 32'd0;
                r_valid <= 1'b0;
                r_state <= c_st_bubble;
            end else begin
                r_pc    <= w_pc_plus4;
                r_instr <= imem_instr;
                r_pc4   <= w_pc_plus4;
                r_valid <= 1'b1;
                r_state <= c_st_fetch;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    // A redirect counts as a bubble even when a stall is also asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetch  <= 32'd0;
            r_perf_bubble <= 32'd0;
        end else if (br_taken) begin
            r_perf_bubble <= r_perf_bubble + 32'd1;
        end else if (!IDstall) begin
            if (IFstall) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end else begin
                r_perf_fetch  <= r_perf_fetch + 32'd1;
            end
        end
    end

    assign perf_fetch  = r_perf_fetch;
    assign perf_bubble = r_perf_bubble;
`endif

    assign imem_addr   = r_pc;
    assign IF_ID_instr = r_instr;
    assign IF_ID_pc4   = r_pc4;
    assign IF_ID_valid = r_valid;
    assign if_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Brief    : Scoreboard bench for if_stage: directed scenarios plus random
//             stall/branch traffic checked against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop      = 32'h0000_0000;
    localparam logic [31:0] c_imem_key = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFstall, IDstall, br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_instr, imem_addr, IF_ID_instr, IF_ID_pc4;
    logic        IF_ID_valid, if_state;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_bubble;
`endif

    if_stage #(.RESET_PC(c_reset_pc), .NOP_INSTR(c_nop)) dut (
        .clk(clk), .reset(reset), .IFstall(IFstall), .IDstall(IDstall),
        .br_taken(br_taken), .br_target(br_target), .imem_instr(imem_instr),
        .imem_addr(imem_addr), .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4),
        .IF_ID_valid(IF_ID_valid),
`ifdef IF_PERF_CNT_EN
        .perf_fetch(perf_fetch), .perf_bubble(perf_bubble),
`endif
        .if_state(if_state)
    );

    always #5 clk = ~clk;

    // Instruction memory: each word is a recognisable function of its address.
    assign imem_instr = imem_addr ^ c_imem_key;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        bubble;
        logic [31:0] n_fetch;
        logic [31:0] n_bubble;
    } exp_t;

    exp_t m;          // reference model state
    exp_t sb_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: architectural effect of one clock edge.
    function automatic exp_t model_step(exp_t s, bit bt, logic [31:0] tgt,
                                        bit ids, bit ifs);
        exp_t n = s;
        if (bt) begin
            n.pc = tgt & ~32'd3;
            n.instr = c_nop; n.pc4 = 0; n.valid = 0; n.bubble = 0;
            n.n_bubble = s.n_bubble + 1;
        end else if (ids) begin
            n = s;
        end else if (ifs) begin
            n.instr = c_nop; n.pc4 = 0; n.valid = 0; n.bubble = 1;
            n.n_bubble = s.n_bubble + 1;
        end else begin
            n.instr = s.pc ^ c_imem_key;
            n.pc4 = s.pc + 4; n.pc = s.pc + 4; n.valid = 1; n.bubble = 0;
            n.n_fetch = s.n_fetch + 1;
        end
        return n;
    endfunction

    function automatic exp_t model_reset();
        exp_t r;
        r.pc = c_reset_pc; r.instr = c_nop; r.pc4 = 0; r.valid = 0;
        r.bubble = 0; r.n_fetch = 0; r.n_bubble = 0;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Monitor: compares DUT outputs with the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("imem_addr", imem_addr, e.pc);
                check("IF_ID_instr", IF_ID_instr, e.instr);
                check("IF_ID_pc4", IF_ID_pc4, e.pc4);
                check("IF_ID_valid", {31'd0, IF_ID_valid}, {31'd0, e.valid});
                check("if_state", {31'd0, if_state}, {31'd0, e.bubble});
`ifdef IF_PERF_CNT_EN
                check("perf_fetch", perf_fetch, e.n_fetch);
                check("perf_bubble", perf_bubble, e.n_bubble);
`endif
            end
        end
    end

    // Called at posedge+1: apply inputs, advance one edge, queue expectation.
    task automatic step(bit bt, logic [31:0] tgt, bit ids, bit ifs);
        br_taken = bt; br_target = tgt; IDstall = ids; IFstall = ifs;
        m = model_step(m, bt, tgt, ids, ifs);
        @(posedge clk); #1;
        sb_q.push_back(m);
    endtask

    task automatic async_reset_check();
        reset = 1'b1;
        #1;
        m = model_reset();
        sb_q.push_back(m);
        ->sample_ev;
        #1;
    endtask

    initial begin
        br_taken = 0; br_target = 0; IDstall = 0; IFstall = 0;
        reset = 1'b0;
        async_reset_check();
        @(posedge clk); #1;
        reset = 1'b0;

        // Four free fetches then a 3-cycle data-hazard freeze at PC=0x10.
        repeat (4) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0);
        // PC=0x20: two fetch bubbles, then fetch resumes at 0x20.
        repeat (2) step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
        // Redirect overrides a simultaneous data stall, and an IFstall.
        step(1, 32'h0000_0103, 1, 0);
        step(1, 32'h0000_0040, 0, 1);
        // Wrap of PC+4 at the top of the address space.
        step(1, 32'hFFFF_FFFE, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        // Reset asserted mid-bubble, observed without any clock edge.
        step(0, 0, 0, 1);
        @(negedge clk); #1;
        async_reset_check();
        @(posedge clk); #1;
        reset = 1'b0;

        // Counter scenario from reset: 5 fetches, 2 IFstall, 1 branch, 3 IDstall.
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1);
        repeat (3) step(0, 0, 1, 0);
        step(1, 32'h0000_0200, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            int unsigned r = $urandom_range(0, 99);
            step(r < 10, $urandom, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 25);
        end

        step(0, 0, 0, 0);
        @(negedge clk); #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
